// File: rtl/vedic_dot_product_accumulator.sv
// Streaming multiply-accumulate stage built on a 16x16 Vedic multiplier.
// It sums operand-pair products per frame and emits the dot product, beat count and overflow flag.

module vedic_mul_core #(
    parameter int W = 16
) (
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic [2*W-1:0] o_p
);
    localparam int H = W / 2;

    generate
        if (W == 2) begin : g_base
            // Urdhva-Tiryagbhyam on two bits: vertical, crosswise, vertical with carries.
            logic w_cross0;
            logic w_cross1;
            logic w_carry1;
            logic w_high;
            assign w_cross0 = i_a[1] & i_b[0];
            assign w_cross1 = i_a[0] & i_b[1];
            assign w_carry1 = w_cross0 & w_cross1;
            assign w_high   = i_a[1] & i_b[1];
            assign o_p      = {w_high & w_carry1, w_high ^ w_carry1, w_cross0 ^ w_cross1, i_a[0] & i_b[0]};
        end else begin : g_split
            logic [W-1:0] w_q0;
            logic [W-1:0] w_q1;
            logic [W-1:0] w_q2;
            logic [W-1:0] w_q3;
            logic [W:0]   w_mid;

            vedic_mul_core #(.W(H)) u_ll (.i_a(i_a[H-1:0]), .i_b(i_b[H-1:0]), .o_p(w_q0));
            vedic_mul_core #(.W(H)) u_hl (.i_a(i_a[W-1:H]), .i_b(i_b[H-1:0]), .o_p(w_q1));
            vedic_mul_core #(.W(H)) u_lh (.i_a(i_a[H-1:0]), .i_b(i_b[W-1:H]), .o_p(w_q2));
            vedic_mul_core #(.W(H)) u_hh (.i_a(i_a[W-1:H]), .i_b(i_b[W-1:H]), .o_p(w_q3));

            // The two crosswise products share weight 2^H; their sum keeps its carry bit.
            assign w_mid = {1'b0, w_q1} + {1'b0, w_q2};
            assign o_p   = {w_q3, w_q0} + {{(W-H-1){1'b0}}, w_mid, {H{1'b0}}};
        end
    endgenerate
endmodule

module sixteen_bit_vedic_multiplier (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [31:0] o_p
);
    vedic_mul_core #(.W(16)) u_core (.i_a(i_a), .i_b(i_b), .o_p(o_p));
endmodule

module vedic_dot_product_accumulator #(
    parameter int ACC_W = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in1,
    input  logic [15:0]      in2,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out,
    output logic [15:0]      out_count,
    output logic             out_ovf
);
    logic             r_s1Valid;
    logic             r_s1Last;
    logic [15:0]      r_s1A;
    logic [15:0]      r_s1B;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [15:0]      r_cnt;
    logic             r_outValid;
    logic [ACC_W-1:0] r_out;
    logic [15:0]      r_outCount;
    logic             r_outOvf;

    logic [31:0]      w_product;
    logic [ACC_W:0]   w_sum;
    logic [15:0]      w_cntNext;
    logic             w_advance;
    logic             w_accept;

    sixteen_bit_vedic_multiplier u_mul (.i_a(r_s1A), .i_b(r_s1B), .o_p(w_product));

    assign w_sum     = {1'b0, r_acc} + {{(ACC_W-31){1'b0}}, w_product};
    assign w_cntNext = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

    // Only a last beat can be held back, and only by an unconsumed result.
    assign w_advance = r_s1Valid && (!r_s1Last || !r_outValid || out_ready);
    assign in_ready  = !r_s1Valid || w_advance;
    assign w_accept  = in_valid && in_ready;

    assign out_valid = r_outValid;
    assign out       = r_out;
    assign out_count = r_outCount;
    assign out_ovf   = r_outOvf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Valid  <= 1'b0;
            r_s1Last   <= 1'b0;
            r_s1A      <= '0;
            r_s1B      <= '0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_cnt      <= '0;
            r_outValid <= 1'b0;
            r_out      <= '0;
            r_outCount <= '0;
            r_outOvf   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1Valid <= 1'b1;
                r_s1Last  <= in_last;
                r_s1A     <= in1;
                r_s1B     <= in2;
            end else if (w_advance) begin
                r_s1Valid <= 1'b0;
            end

            if (r_outValid && out_ready) begin
                r_outValid <= 1'b0;
            end

            // A last beat overrides the consume above so back-to-back results have no bubble.
            if (w_advance) begin
                if (r_s1Last) begin
                    r_out      <= w_sum[ACC_W-1:0];
                    r_outOvf   <= r_ovf | w_sum[ACC_W];
                    r_outCount <= w_cntNext;
                    r_outValid <= 1'b1;
                    r_acc      <= '0;
                    r_ovf      <= 1'b0;
                    r_cnt      <= '0;
                end else begin
                    r_acc <= w_sum[ACC_W-1:0];
                    r_ovf <= r_ovf | w_sum[ACC_W];
                    r_cnt <= w_cntNext;
                end
            end
        end
    end
endmodule

// File: tb/tb_vedic_dot_product_accumulator.sv
// Directed bench for the dot-product accumulator: a 40-bit and a 32-bit instance
// share one stimulus stream so the wrap/overflow behaviour is visible on the narrow one.

module tb_vedic_dot_product_accumulator;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;
    logic [15:0] in1;
    logic [15:0] in2;

    logic        in_ready40;
    logic        out_valid40;
    logic [39:0] out40;
    logic [15:0] out_count40;
    logic        out_ovf40;

    logic        in_ready32;
    logic        out_valid32;
    logic [31:0] out32;
    logic [15:0] out_count32;
    logic        out_ovf32;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        last;
        logic [39:0] expOut;
        logic [15:0] expCnt;
        logic        expOvf40;
        logic        expOvf32;
    } beat_t;

    beat_t beats[16];

    vedic_dot_product_accumulator #(.ACC_W(40)) dut40 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready40),
        .in1(in1), .in2(in2), .in_last(in_last), .out_valid(out_valid40),
        .out_ready(out_ready), .out(out40), .out_count(out_count40), .out_ovf(out_ovf40)
    );

    vedic_dot_product_accumulator #(.ACC_W(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
        .in1(in1), .in2(in2), .in_last(in_last), .out_valid(out_valid32),
        .out_ready(out_ready), .out(out32), .out_count(out_count32), .out_ovf(out_ovf32)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Presents one pair and returns at the negedge after it is accepted.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic last,
                                 output int stalls);
        in1      = a;
        in2      = b;
        in_last  = last;
        in_valid = 1'b1;
        stalls   = 0;
        #1;
        while (!in_ready40 && stalls < 20) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (stalls >= 20) begin
            checkOutput("accept_timeout", 48'(stalls), 48'd0);
        end else begin
            checkOutput("in_ready32_on_accept", 48'(in_ready32), 48'd1);
            @(negedge clk);
        end
    endtask

    task automatic waitResult(input string tag, input logic [39:0] e, input logic [15:0] c,
                              input logic o40, input logic o32);
        int cyc = 0;
        in_valid = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid40 && cyc < 10);
        checkOutput({tag, "_latency"}, 48'(cyc), 48'd1);
        checkOutput({tag, "_valid40"}, 48'(out_valid40), 48'd1);
        checkOutput({tag, "_out40"}, 48'(out40), 48'(e));
        checkOutput({tag, "_count40"}, 48'(out_count40), 48'(c));
        checkOutput({tag, "_ovf40"}, 48'(out_ovf40), 48'(o40));
        checkOutput({tag, "_valid32"}, 48'(out_valid32), 48'd1);
        checkOutput({tag, "_out32"}, 48'(out32), 48'(e[31:0]));
        checkOutput({tag, "_count32"}, 48'(out_count32), 48'(c));
        checkOutput({tag, "_ovf32"}, 48'(out_ovf32), 48'(o32));
    endtask

    initial begin
        int st;
        logic [39:0] b2b[3];

        beats[0]  = '{16'h0003, 16'h0005, 1'b1, 40'd15,            16'd1, 1'b0, 1'b0};
        beats[1]  = '{16'hFFFF, 16'hFFFF, 1'b0, 40'd0,             16'd0, 1'b0, 1'b0};
        beats[2]  = '{16'hFFFF, 16'hFFFF, 1'b0, 40'd0,             16'd0, 1'b0, 1'b0};
        beats[3]  = '{16'hFFFF, 16'hFFFF, 1'b0, 40'd0,             16'd0, 1'b0, 1'b0};
        beats[4]  = '{16'hFFFF, 16'hFFFF, 1'b1, 40'h3_FFF8_0004,   16'd4, 1'b0, 1'b1};
        beats[5]  = '{16'hFFFF, 16'hFFFF, 1'b0, 40'd0,             16'd0, 1'b0, 1'b0};
        beats[6]  = '{16'hFFFF, 16'hFFFF, 1'b1, 40'h1_FFFC_0002,   16'd2, 1'b0, 1'b1};
        beats[7]  = '{16'h0002, 16'h0002, 1'b1, 40'd4,             16'd1, 1'b0, 1'b0};
        beats[8]  = '{16'h1234, 16'h0010, 1'b0, 40'd0,             16'd0, 1'b0, 1'b0};
        beats[9]  = '{16'h00FF, 16'h0100, 1'b0, 40'd0,             16'd0, 1'b0, 1'b0};
        beats[10] = '{16'hABCD, 16'h0001, 1'b1, 40'h2_CE0D,        16'd3, 1'b0, 1'b0};
        beats[11] = '{16'hF0F0, 16'h0F0F, 1'b1, 40'hE2C_2E10,      16'd1, 1'b0, 1'b0};
        beats[12] = '{16'h0001, 16'hFFFF, 1'b0, 40'd0,             16'd0, 1'b0, 1'b0};
        beats[13] = '{16'hFFFF, 16'h0001, 1'b1, 40'h1_FFFE,        16'd2, 1'b0, 1'b0};
        beats[14] = '{16'h8000, 16'h0002, 1'b0, 40'd0,             16'd0, 1'b0, 1'b0};
        beats[15] = '{16'h0003, 16'h0007, 1'b1, 40'h1_0015,        16'd2, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in1       = '0;
        in2       = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_in_ready", 48'(in_ready40), 48'd1);
        checkOutput("reset_out_valid", 48'(out_valid40), 48'd0);
        checkOutput("reset_out", 48'(out40), 48'd0);
        checkOutput("reset_out_count", 48'(out_count40), 48'd0);
        checkOutput("reset_out_ovf", 48'(out_ovf40), 48'd0);
        checkOutput("reset_out32", 48'(out32), 48'd0);
        @(negedge clk);

        // Table frames with the result port always ready: beats go in on consecutive cycles.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(beats[i].a, beats[i].b, beats[i].last, st);
            checkOutput($sformatf("row%0d_stalls", i), 48'(st), 48'd0);
            if (beats[i].last) begin
                waitResult($sformatf("row%0d", i), beats[i].expOut, beats[i].expCnt,
                           beats[i].expOvf40, beats[i].expOvf32);
            end
        end
        @(negedge clk);

        // Backpressure: the second frame's last beat parks in stage 1 until release.
        out_ready = 1'b0;
        applyStimulus(16'd1, 16'd1, 1'b1, st);
        waitResult("bp_first", 40'd1, 16'd1, 1'b0, 1'b0);
        #1;
        checkOutput("bp_ready_before", 48'(in_ready40), 48'd1);
        applyStimulus(16'd2, 16'd3, 1'b0, st);
        checkOutput("bp_nonlast_stalls", 48'(st), 48'd0);
        applyStimulus(16'd4, 16'd5, 1'b1, st);
        checkOutput("bp_last_stalls", 48'(st), 48'd0);
        in_valid = 1'b0;
        #1;
        checkOutput("bp_ready_blocked", 48'(in_ready40), 48'd0);
        checkOutput("bp_out_held", 48'(out40), 48'd1);
        checkOutput("bp_count_held", 48'(out_count40), 48'd1);
        repeat (3) @(negedge clk);
        checkOutput("bp_ready_still_low", 48'(in_ready40), 48'd0);
        checkOutput("bp_out_still_held", 48'(out40), 48'd1);
        checkOutput("bp_valid_held", 48'(out_valid40), 48'd1);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_out", 48'(out40), 48'd26);
        checkOutput("bp_release_count", 48'(out_count40), 48'd2);
        checkOutput("bp_release_valid", 48'(out_valid40), 48'd1);
        @(negedge clk);
        checkOutput("bp_consumed_valid", 48'(out_valid40), 48'd0);

        // Back-to-back single-beat frames: results on consecutive cycles with no bubble.
        b2b[0] = 40'd2;
        b2b[1] = 40'd12;
        b2b[2] = 40'd30;
        for (int i = 0; i < 3; i++) begin
            in1      = 16'(2 * i + 1);
            in2      = 16'(2 * i + 2);
            in_last  = 1'b1;
            in_valid = 1'b1;
            #1;
            checkOutput($sformatf("b2b_ready%0d", i), 48'(in_ready40), 48'd1);
            @(negedge clk);
            if (i > 0) begin
                checkOutput($sformatf("b2b_out%0d", i - 1), 48'(out40), 48'(b2b[i - 1]));
                checkOutput($sformatf("b2b_valid%0d", i - 1), 48'(out_valid40), 48'd1);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b_out2", 48'(out40), 48'(b2b[2]));
        checkOutput("b2b_valid2", 48'(out_valid40), 48'd1);
        @(negedge clk);

        // Reset mid-frame: the partial sum must not leak into the next frame.
        applyStimulus(16'd7, 16'd7, 1'b0, st);
        applyStimulus(16'd8, 16'd8, 1'b0, st);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rstmid_valid", 48'(out_valid40), 48'd0);
        checkOutput("rstmid_out", 48'(out40), 48'd0);
        checkOutput("rstmid_count", 48'(out_count40), 48'd0);
        checkOutput("rstmid_ready", 48'(in_ready40), 48'd1);
        @(negedge clk);
        checkOutput("rstmid_idle_valid", 48'(out_valid40), 48'd0);
        applyStimulus(16'd1, 16'd1, 1'b1, st);
        waitResult("rstmid_new", 40'd1, 16'd1, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vedic_dot_product_accumulator.md
# vedic_dot_product_accumulator

Pipelined streaming multiply-accumulate stage wrapped around one `sixteen_bit_vedic_multiplier` instance. It accepts a frame of 16-bit unsigned operand pairs over a valid/ready handshake, multiplies each pair, and sums the 32-bit products. At the last beat of each frame it emits the dot product, a beat count and an overflow flag. It is the consumer of the 16x16 Vedic product path and feeds downstream approximate-computing error-measurement logic.

## Interface
- `ACC_W`, 40: accumulator and result width in bits; legal range 32..48.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept the operand pair this cycle.
- `in1`  in  16  unsigned operand A.
- `in2`  in  16  unsigned operand B.
- `in_last`  in  1  marks the final pair of a frame.
- `out_valid`  out  1  result register holds a completed frame.
- `out_ready`  in  1  downstream accepts the result.
- `out`  out  ACC_W  dot product of the frame, modulo 2^ACC_W.
- `out_count`  out  16  number of beats in the frame, saturating at 16'hFFFF.
- `out_ovf`  out  1  sticky flag: at least one accumulation carried out of ACC_W in this frame.

## Operation
- **Stage 1 (operand register).**
  - On an accepting edge (`in_valid && in_ready`), capture `in1`, `in2` and `in_last`, and set `s1_valid`.
  - The multiplier instance is driven combinationally from the stage-1 registers and produces the 32-bit product `p`.
- **Stage 2 (accumulate).** The stage-1 beat advances when `s1_valid && (!s1_last || !out_valid || out_ready)`.
  - **Advance, non-last beat:** `acc <= acc + zero-extended p`. Set `ovf` if the sum carries out of bit ACC_W-1. `cnt <= cnt + 1`, saturating at 16'hFFFF.
  - **Advance, last beat:** load `out <= acc + p`, `out_ovf <= ovf | carry` and `out_count <= sat(cnt + 1)`, and set `out_valid`. Clear `acc`, `ovf` and `cnt` to 0 so the next frame starts clean in the same cycle.
- **Ready.** `in_ready = !s1_valid || advance`, so stage 1 is refilled in the same cycle it drains.
- **Result handshake.**
  - Clear `out_valid` on `out_valid && out_ready` unless a new last beat loads the result register in that same cycle.
  - While `out_valid` is high, `out`, `out_count` and `out_ovf` must hold stable.
- **Arithmetic.** All arithmetic is unsigned. Wrap-around is modulo 2^ACC_W, and `out_ovf` reports it. With ACC_W = 40, up to 256 full-scale products fit without overflow.
- **Single-beat frame.** A frame with `in_last` on its first beat is legal; the result is that product alone with `out_count` = 1.
- **Frame boundaries.** There are no gaps between frames and no idle beat is required between them.

## Timing
- **Reset values.** `in_ready` = 1 (since `s1_valid` = 0). `out_valid` = 0, `out` = 0, `out_count` = 0, `out_ovf` = 0. Internal `acc`, `ovf`, `cnt` and `s1_valid` are all 0.
- **Throughput.** One pair per cycle whenever the result register is not blocked.
- **Latency.** If the last pair is accepted at edge k, `out_valid` is high after edge k+1 (2-cycle latency from presentation).
- **Backpressure.**
  - Only a last beat stalls. It waits in stage 1 while `out_valid && !out_ready`.
  - During that stall, `in_ready` stays low and stage 1 holds.
  - Non-last beats keep advancing into `acc` even while the previous result is unaccepted.
- **Simultaneous events.** If `out_ready` is high while a last beat sits in stage 1 with `out_valid` high, the old result is consumed and the new one loaded on the same edge. `out_valid` stays high with no bubble.
- **Reset mid-operation.** `rst` discards stage 1, the partial accumulator and any pending result on the next edge. There is no output for the interrupted frame.
- **Input stability.** `in1`, `in2` and `in_last` need only be stable while `in_valid` is high. Inputs are ignored when `in_valid` is low.

## Test plan
- **Single-beat frame.** Pair (3, 5) with `in_last` = 1 -> after 2 cycles: `out` = 15, `out_count` = 1, `out_ovf` = 0.
- **Full-scale frame, ACC_W = 40.** Four pairs (16'hFFFF, 16'hFFFF), last on the 4th -> `out` = 40'h3_FFF8_0004, `out_count` = 4, `out_ovf` = 0. Input is accepted on 4 consecutive cycles.
- **Overflow, ACC_W = 32.** Two pairs (16'hFFFF, 16'hFFFF) -> `out` = 32'hFFFC_0002, `out_ovf` = 1. The next frame (2, 2) gives `out` = 4 and `out_ovf` = 0, confirming the sticky flag clears per frame.
- **Backpressure.**
  - Setup: hold `out_ready` = 0 and send frames {(1,1) last} then {(2,3), (4,5) last}.
  - Expected while blocked: first `out` = 1 held stable; `in_ready` drops only when (4,5) reaches stage 1.
  - Expected on release: after one cycle of `out_ready` = 1, `out` = 26 and `out_count` = 2.
- **Back-to-back single-beat frames.** With `out_ready` tied high, send (1,2), (3,4), (5,6), each with `in_last` = 1 -> `out` = 2, 12, 30 on consecutive cycles, and `out_valid` continuously high.
- **Reset mid-frame.** Accept (7,7) and (8,8) non-last, pulse `rst`, then send (1,1) last -> `out` = 1, `out_count` = 1; no result ever appears for the aborted frame.
